stereo_pair_aligner: RTL and testbench
======================================

Name: stereo_pair_aligner

Overview:
- Upstream feeder of the SGM disparity core.
- Input: a side-by-side stereo stream, one 8-bit pixel per clock. Each active line is HALF_IMG_WIDTH left-image pixels followed by HALF_IMG_WIDTH right-image pixels.
- Stores the left half of each line in a line buffer. While the right half arrives, it replays the stored pixels, so the core sees column-aligned left/right pairs in the second half of every line, matching the core's col >= HALF_IMG_WIDTH processing window.
- Forwards delay-matched sync signals so the core's coordinate counter stays consistent.

Parameters:
- HALF_IMG_WIDTH, 640, pixels per eye per line.
- PIXEL_BITS, 8, pixel width.
- COL_WIDTH, 11, column counter width; must satisfy 2^COL_WIDTH > 2*HALF_IMG_WIDTH.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  synchronous, active-low reset.
- de_in  in  1  data enable.
- h_sync_in  in  1  horizontal sync.
- v_sync_in  in  1  vertical sync.
- pixel_in  in  PIXEL_BITS  side-by-side stream pixel.
- de_out  out  1  de_in delayed 2 cycles.
- h_sync_out  out  1  h_sync_in delayed 2 cycles.
- v_sync_out  out  1  v_sync_in delayed 2 cycles.
- pixel_left  out  PIXEL_BITS  buffered left pixel at the same column as pixel_right.
- pixel_right  out  PIXEL_BITS  right pixel.
- pair_valid  out  1  pixel_left/pixel_right form a valid pair.
- line_error  out  1  one-cycle pulse on a malformed line.

Behaviour:
- Clocking and reset: one clock (clk); rst_n is synchronous and active-low.
- Reset state: all outputs 0, column counter 0, FSM in WAIT_BLANK, 2-stage sync delay line cleared. RAM contents are not reset.
- Latency: fixed 2 cycles from any input sample to its outputs, for sync, pixel and validity alike.
- Column counter col:
  - Increments on each cycle with de_in=1.
  - Clears on the de_in falling edge, and on any cycle with v_sync_in=1.
- FSM states:
  - WAIT_BLANK: ignore input until de_in=0, then go to LEFT. Entered from reset, so a reset released mid-line discards the rest of that line.
  - LEFT: with de_in=1, write pixel_in to RAM[col].
    - col == HALF_IMG_WIDTH-1 with de_in=1: go to RIGHT.
    - de_in falls early: pulse line_error, stay in LEFT with col=0.
  - RIGHT: with de_in=1, read RAM[col-HALF_IMG_WIDTH]. The read is synchronous (1 cycle); pixel_right is pipelined through the matching stage.
    - col == 2*HALF_IMG_WIDTH-1: go to LEFT.
    - de_in falls early: pulse line_error, go to LEFT. Pairs already emitted remain valid.
  - OVERRUN: entered when de_in is still 1 after col reaches 2*HALF_IMG_WIDTH (i.e. from LEFT after RIGHT completed). Pulse line_error once, ignore pixels, return to LEFT on de_in falling.
- Outputs outside valid pairs: pair_valid=1 exactly for the 2-cycle-delayed RIGHT-state samples. Whenever pair_valid=0, pixel_left=pixel_right=0.
- v_sync_in=1 in any state: col=0 and the FSM goes to LEFT. If the line was unfinished, pulse line_error.
- RAM port conflict: none. Writes happen only in LEFT and reads only in RIGHT; one line buffer of HALF_IMG_WIDTH x PIXEL_BITS suffices.
- Back-to-back lines with a single blanking cycle must work: the col clear and FSM transitions complete in that cycle.
- line_error is never asserted for more than one consecutive cycle per event.

Decomposition:
- Shared package/include holds HALF_IMG_WIDTH, PIXEL_BITS, COL_WIDTH defaults, the FSM state encoding (WAIT_BLANK, LEFT, RIGHT, OVERRUN), and clog2_fun for address width.
- One sub-module, line_buffer_ram: simple dual-port, HALF_IMG_WIDTH deep, registered read, inferable as block RAM.
- FSM, counter and delay pipeline stay in stereo_pair_aligner.

Test Plan:
- Normal line (HALF_IMG_WIDTH=8 for the bench):
  - Stimulus: release reset in blanking; 16 de cycles, pixel_in = 0x10+k for k<8, then 0xA0+k.
  - Required: 8 cycles of pair_valid=1 starting 2 cycles after the first right pixel, with (pixel_left, pixel_right) = (0x10+j, 0xA0+j) for j=0..7; line_error stays 0; de_out equals de_in delayed 2.
- Back-to-back lines:
  - Stimulus: two lines separated by 1 blanking cycle, second line left pixels 0x20+k.
  - Required: second line pairs show pixel_left=0x20+j; no stale 0x10 values.
- Short line:
  - Stimulus: de_in drops after 11 pixels.
  - Required: exactly 3 valid pairs (j=0..2), one line_error pulse, next line aligns correctly.
- Long line:
  - Stimulus: 19 de cycles.
  - Required: 8 valid pairs, one line_error pulse 2 cycles after the 17th pixel, pair_valid=0 for pixels 17-19.
- Reset mid-operation:
  - Stimulus: rst_n=0 for 1 cycle at left-half pixel 5, then the line continues.
  - Required: all outputs 0 next cycle; no pair_valid for the rest of that line; the following line is fully correct.
- v_sync mid-line:
  - Stimulus: v_sync_in=1 during right-half pixel 3.
  - Required: line_error pulse, pair_valid drops after pairs 0..2, next frame's first line is correct.

Source files
------------

// File: rtl/stereo_pair_aligner_pkg.sv
// stereo_pair_aligner_pkg: shared defaults, line FSM encoding and address-width helper
package stereo_pair_aligner_pkg;

    localparam int DEF_HALF_IMG_WIDTH = 640;
    localparam int DEF_PIXEL_BITS     = 8;
    localparam int DEF_COL_WIDTH      = 11;

    typedef enum logic [1:0] {
        WAIT_BLANK,
        LEFT,
        RIGHT,
        OVERRUN
    } state_t;

    function automatic int clog2_fun(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stereo_pair_aligner_line_buffer_ram.sv
// line_buffer_ram: simple dual-port line buffer with registered read, maps onto block RAM
module line_buffer_ram
    import stereo_pair_aligner_pkg::*;
#(
    parameter int DEPTH = DEF_HALF_IMG_WIDTH,
    parameter int WIDTH = DEF_PIXEL_BITS,
    parameter int AW    = clog2_fun(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // one write port and one registered read port; contents are never reset
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
        if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/stereo_pair_aligner.sv
// stereo_pair_aligner: turns a side-by-side stereo stream into column-aligned left/right pixel pairs
module stereo_pair_aligner
    import stereo_pair_aligner_pkg::*;
#(
    parameter int HALF_IMG_WIDTH = DEF_HALF_IMG_WIDTH,
    parameter int PIXEL_BITS     = DEF_PIXEL_BITS,
    parameter int COL_WIDTH      = DEF_COL_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  de_in,
    input  logic                  h_sync_in,
    input  logic                  v_sync_in,
    input  logic [PIXEL_BITS-1:0] pixel_in,
    output logic                  de_out,
    output logic                  h_sync_out,
    output logic                  v_sync_out,
    output logic [PIXEL_BITS-1:0] pixel_left,
    output logic [PIXEL_BITS-1:0] pixel_right,
    output logic                  pair_valid,
    output logic                  line_error
);

    localparam int AW = clog2_fun(HALF_IMG_WIDTH);
    localparam logic [COL_WIDTH-1:0] LAST_LEFT   = COL_WIDTH'(HALF_IMG_WIDTH - 1);
    localparam logic [COL_WIDTH-1:0] FIRST_RIGHT = COL_WIDTH'(HALF_IMG_WIDTH);
    localparam logic [COL_WIDTH-1:0] LAST_RIGHT  = COL_WIDTH'(2 * HALF_IMG_WIDTH - 1);
    localparam logic [AW-1:0]        HALF_A      = AW'(HALF_IMG_WIDTH);

    state_t                state_q;
    logic [COL_WIDTH-1:0]  col_q;
    logic                  in_left;
    logic                  wr_en;
    logic                  rd_en;
    logic [AW-1:0]         rd_addr;
    logic [PIXEL_BITS-1:0] rd_data;
    logic [2:0]            sync1_q;
    logic [2:0]            sync2_q;
    logic                  pv1_q;
    logic                  err1_q;
    logic [PIXEL_BITS-1:0] pix1_q;
    logic                  pair_valid_q;
    logic                  line_error_q;
    logic [PIXEL_BITS-1:0] pixel_left_q;
    logic [PIXEL_BITS-1:0] pixel_right_q;

    // a left half has started but not yet filled the buffer
    assign in_left = (col_q != '0) && (col_q < FIRST_RIGHT);
    assign wr_en   = (state_q == LEFT) && de_in && !v_sync_in && (col_q < FIRST_RIGHT);
    assign rd_en   = (state_q == RIGHT) && de_in && !v_sync_in;
    // col - HALF fits in AW bits, so the subtraction can be done modulo 2^AW
    assign rd_addr = col_q[AW-1:0] - HALF_A;

    line_buffer_ram #(
        .DEPTH (HALF_IMG_WIDTH),
        .WIDTH (PIXEL_BITS),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (col_q[AW-1:0]),
        .wr_data_i (pixel_in),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    // line FSM and column counter; the error flag is registered here as stage 1 of the delay line
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= WAIT_BLANK;
            col_q   <= '0;
            err1_q  <= 1'b0;
        end else begin
            col_q  <= (v_sync_in || !de_in) ? '0 : col_q + 1'b1;
            err1_q <= 1'b0;
            if (v_sync_in) begin
                state_q <= LEFT;
                err1_q  <= (state_q == RIGHT) || ((state_q == LEFT) && in_left);
            end else begin
                case (state_q)
                    WAIT_BLANK: if (!de_in) state_q <= LEFT;
                    LEFT: begin
                        if (!de_in) begin
                            err1_q <= in_left;
                        end else if (col_q >= FIRST_RIGHT) begin
                            state_q <= OVERRUN;
                            err1_q  <= 1'b1;
                        end else if (col_q == LAST_LEFT) begin
                            state_q <= RIGHT;
                        end
                    end
                    RIGHT: begin
                        if (!de_in || col_q == LAST_RIGHT) begin
                            state_q <= LEFT;
                            err1_q  <= !de_in;
                        end
                    end
                    OVERRUN: if (!de_in) state_q <= LEFT;
                    default: state_q <= WAIT_BLANK;
                endcase
            end
        end
    end

    // two-stage delay line: stage 1 lines up with the RAM read, stage 2 masks and registers outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q       <= '0;
            pv1_q         <= 1'b0;
            pix1_q        <= '0;
            sync2_q       <= '0;
            pair_valid_q  <= 1'b0;
            line_error_q  <= 1'b0;
            pixel_left_q  <= '0;
            pixel_right_q <= '0;
        end else begin
            sync1_q       <= {de_in, h_sync_in, v_sync_in};
            pv1_q         <= rd_en;
            pix1_q        <= pixel_in;
            sync2_q       <= sync1_q;
            pair_valid_q  <= pv1_q;
            line_error_q  <= err1_q;
            pixel_left_q  <= pv1_q ? rd_data : '0;
            pixel_right_q <= pv1_q ? pix1_q : '0;
        end
    end

    assign de_out      = sync2_q[2];
    assign h_sync_out  = sync2_q[1];
    assign v_sync_out  = sync2_q[0];
    assign pair_valid  = pair_valid_q;
    assign line_error  = line_error_q;
    assign pixel_left  = pixel_left_q;
    assign pixel_right = pixel_right_q;

endmodule

// File: tb/tb_stereo_pair_aligner.sv
// tb_stereo_pair_aligner: randomized scoreboard bench against a line-level reference model
module tb_stereo_pair_aligner;

    localparam int H = 8;

    typedef struct {
        int         t;
        logic [7:0] l;
        logic [7:0] r;
    } pair_t;

    logic       clk;
    logic       rst_n;
    logic       de_in;
    logic       h_sync_in;
    logic       v_sync_in;
    logic [7:0] pixel_in;
    logic       de_out;
    logic       h_sync_out;
    logic       v_sync_out;
    logic [7:0] pixel_left;
    logic [7:0] pixel_right;
    logic       pair_valid;
    logic       line_error;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    pair_t      pq[$];
    int         eq[$];
    bit [2:0]   exp_sync [0:8191];
    int         n;
    bit         synced;
    logic [7:0] left_mem [H];

    stereo_pair_aligner #(
        .HALF_IMG_WIDTH (H),
        .PIXEL_BITS     (8),
        .COL_WIDTH      (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .de_in       (de_in),
        .h_sync_in   (h_sync_in),
        .v_sync_in   (v_sync_in),
        .pixel_in    (pixel_in),
        .de_out      (de_out),
        .h_sync_out  (h_sync_out),
        .v_sync_out  (v_sync_out),
        .pixel_left  (pixel_left),
        .pixel_right (pixel_right),
        .pair_valid  (pair_valid),
        .line_error  (line_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    endtask

    // one input sample; the model predicts what appears at the outputs two cycles later
    task automatic drv(input bit rst, input bit de, input bit hs, input bit vs, input logic [7:0] pix);
        @(negedge clk);
        rst_n     = !rst;
        de_in     = de;
        h_sync_in = hs;
        v_sync_in = vs;
        pixel_in  = pix;
        if (rst) begin
            synced = 1'b0;
            n      = 0;
            while (pq.size() > 0 && pq[$].t > cyc) void'(pq.pop_back());
            while (eq.size() > 0 && eq[$] > cyc) void'(eq.pop_back());
            exp_sync[cyc+1] = 3'b000;
            exp_sync[cyc+2] = 3'b000;
        end else begin
            exp_sync[cyc+2] = {de, hs, vs};
            if (vs || !de) begin
                if (synced && n > 0 && n < 2 * H) eq.push_back(cyc + 2);
                synced = 1'b1;
                n      = 0;
            end else begin
                if (synced) begin
                    if (n < H) left_mem[n] = pix;
                    else if (n < 2 * H) pq.push_back(pair_t'{cyc + 2, left_mem[n-H], pix});
                    else if (n == 2 * H) eq.push_back(cyc + 2);
                end
                n++;
            end
        end
    endtask

    task automatic line(input int len, input logic [7:0] lb, input logic [7:0] rb, input int vs_at, input int rst_at);
        for (int k = 0; k < len; k++) begin
            drv(k == rst_at, 1'b1, 1'b0, k == vs_at, (k < H) ? lb + 8'(k) : rb + 8'(k - H));
            if (k == vs_at) break;
        end
    endtask

    task automatic blank(input int len, input bit vs);
        for (int k = 0; k < len; k++) drv(1'b0, 1'b0, k == 0, vs && k == 0, 8'($urandom));
    endtask

    // monitor: checks every cycle and pops the scoreboard whenever an expected event is due
    always @(negedge clk) begin : mon
        bit ev;
        bit ee;
        if (cyc >= 1) begin
            chk("sync_delay", 32'({de_out, h_sync_out, v_sync_out}), 32'(exp_sync[cyc]));
            ev = pq.size() > 0 && pq[0].t == cyc;
            chk("pair_valid", 32'(pair_valid), 32'(ev));
            if (ev) begin
                if (pair_valid) begin
                    chk("pixel_left", 32'(pixel_left), 32'(pq[0].l));
                    chk("pixel_right", 32'(pixel_right), 32'(pq[0].r));
                end
                void'(pq.pop_front());
            end else if (!pair_valid) begin
                chk("idle_pixels", 32'({pixel_left, pixel_right}), 32'(0));
            end
            ee = eq.size() > 0 && eq[0] == cyc;
            chk("line_error", 32'(line_error), 32'(ee));
            if (ee) void'(eq.pop_front());
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int len;
        rst_n     = 1'b0;
        de_in     = 1'b0;
        h_sync_in = 1'b0;
        v_sync_in = 1'b0;
        pixel_in  = 8'h00;
        n         = 0;
        synced    = 1'b0;
        repeat (3) drv(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        blank(2, 1'b0);
        line(16, 8'h10, 8'hA0, -1, -1); blank(1, 1'b0);
        line(16, 8'h20, 8'hB0, -1, -1); blank(1, 1'b0);
        line(11, 8'h30, 8'hC0, -1, -1); blank(2, 1'b0);
        line(16, 8'h40, 8'hD0, -1, -1); blank(1, 1'b0);
        line(19, 8'h50, 8'hE0, -1, -1); blank(1, 1'b0);
        line(16, 8'h60, 8'hF0, -1, -1); blank(2, 1'b0);
        line(16, 8'h70, 8'h80, -1, 5);  blank(1, 1'b0);
        line(16, 8'h11, 8'h91, -1, -1); blank(1, 1'b0);
        line(16, 8'h12, 8'h92, H + 3, -1); blank(2, 1'b1);
        line(16, 8'h13, 8'h93, -1, -1); blank(1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            len = ($urandom_range(3) == 0) ? int'($urandom_range(20, 1)) : 2 * H;
            line(len, 8'($urandom), 8'($urandom), -1, -1);
            blank(int'($urandom_range(3, 1)), $urandom_range(7) == 0);
        end
        blank(4, 1'b0);
        chk("scoreboard_drained", 32'(pq.size() + eq.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
